// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and data width.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_BIT  = 3'd1,
      DATA_BITS  = 3'd2,
      PARITY_BIT = 3'd3,
      STOP_BIT   = 3'd4,
      CLEANUP    = 3'd5
   } uart_rx_state_t;

   function automatic int bit_period(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin; both flops set to 1 on reset
// so an idle-high line never looks like an edge when reset releases.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a live parity_err.
// Valid/error strobes are single-cycle and registered one cycle after the stop-bit sample.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      data_valid,
   output logic                      frame_err,
   output logic                      parity_err,
   output logic                      rx_busy
);

   localparam int BIT_PERIOD  = bit_period(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int TW          = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
   localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_PERIOD - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;
   uart_rx_state_t            state_q, state_d;
   logic [TW-1:0]             tick_q, tick_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      ferr_q, ferr_d;
   logic                      busy_q, busy_d;
   logic                      tick_done;
   logic                      mism;

`ifdef UART_RX_PARITY_EN
   logic mism_q, mism_d;
   logic perr_q, perr_d;
   assign mism       = mism_q;
   assign parity_err = perr_q;
`else
   assign mism       = 1'b0;
   assign parity_err = 1'b0;
`endif

   sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // The start bit is checked at its middle, so it uses the shorter terminal count.
   assign tick_done = (state_q == START_BIT) ? (tick_q == HALF_LAST) : (tick_q == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         mism_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         mism_q  <= mism_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (!rx_s) state_d = START_BIT;
         START_BIT: if (tick_done) state_d = rx_s ? IDLE : DATA_BITS;
`ifdef UART_RX_PARITY_EN
         DATA_BITS:  if (tick_done && bit_q == LAST_BIT) state_d = PARITY_BIT;
         PARITY_BIT: if (tick_done) state_d = STOP_BIT;
`else
         DATA_BITS:  if (tick_done && bit_q == LAST_BIT) state_d = STOP_BIT;
`endif
         STOP_BIT:  if (tick_done) state_d = CLEANUP;
         CLEANUP:   if (rx_s) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      tick_d  = '0;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      busy_d  = busy_q;
`ifdef UART_RX_PARITY_EN
      mism_d  = mism_q;
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               busy_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               mism_d = 1'b0;
`endif
            end
         end
         START_BIT: begin
            if (!tick_done) begin
               tick_d = tick_q + TW'(1);
            end else if (rx_s) begin
               busy_d = 1'b0;
            end else begin
               bit_d = '0;
            end
         end
         DATA_BITS: begin
            if (!tick_done) begin
               tick_d = tick_q + TW'(1);
            end else begin
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + 3'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY_BIT: begin
            if (!tick_done) tick_d = tick_q + TW'(1);
            else            mism_d = rx_s ^ (^shift_q);
         end
`endif
         STOP_BIT: begin
            if (!tick_done) begin
               tick_d = tick_q + TW'(1);
            end else if (!rx_s) begin
               ferr_d = 1'b1;
            end else if (!mism) begin
               data_d  = shift_q;
               valid_d = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
               perr_d = 1'b1;
`endif
            end
         end
         CLEANUP: if (rx_s) busy_d = 1'b0;
         default: busy_d = 1'b0;
      endcase
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at BIT_PERIOD = 16 (160 Hz clock, 10 baud).
module tb_uart_rx;

   localparam int BP = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, frame_err, parity_err, rx_busy;

   // Scoreboard entry: {kind[1:0], data[7:0]}; kind 0 = valid byte, 1 = frame error, 2 = parity error
   logic [9:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   logic       prev_pulse = 1'b0;

   uart_rx #(.CLOCK_FREQ(160), .BAUD_RATE(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Reference: stop low wins over parity; a good frame becomes the new held data_out.
   task automatic send_frame(input logic [7:0] d, input bit par_good, input int stop_low);
      logic [1:0] kind;
`ifdef UART_RX_PARITY_EN
      kind = (stop_low > 0) ? 2'd1 : (par_good ? 2'd0 : 2'd2);
`else
      kind = (stop_low > 0) ? 2'd1 : 2'd0;
`endif
      if (kind == 2'd0) last_good = d;
      exp_q.push_back({kind, last_good});
      drive(1'b0, BP);
      for (int i = 0; i < 8; i++) drive(d[i], BP);
`ifdef UART_RX_PARITY_EN
      drive((^d) ^ ~par_good, BP);
`endif
      if (stop_low > 0) begin
         drive(1'b0, BP * stop_low);
         check("busy_held_low", 32'(rx_busy), 32'd1);
      end
      drive(1'b1, BP);
   endtask

   task automatic check_idle_outputs(input string name, input logic [7:0] exp_data);
      check({name, "_data"}, 32'(data_out), 32'(exp_data));
      check({name, "_busy"}, 32'(rx_busy), 32'd0);
      check({name, "_pulses"}, 32'({data_valid, frame_err, parity_err}), 32'd0);
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst) begin
         prev_pulse <= 1'b0;
      end else begin
         if (data_valid || frame_err || parity_err) begin
            logic [1:0] kind;
            logic [9:0] e;
            check("pulse_exclusive", 32'(32'(data_valid) + 32'(frame_err) + 32'(parity_err)), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            kind = data_valid ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {22'd0, kind, data_out}, 32'h3ff);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", 32'(kind), 32'(e[9:8]));
               check("pulse_data", 32'(data_out), 32'(e[7:0]));
            end
         end
         prev_pulse <= data_valid | frame_err | parity_err;
      end
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset", 8'h00);
      rst = 1'b0;
      drive(1'b1, 4);

      send_frame(8'hA5, 1'b1, 0);
      drive(1'b1, 4);
      check_idle_outputs("a5_after", 8'hA5);

      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      drive(1'b1, 4);
      check_idle_outputs("b2b_after", 8'hFF);

      drive(1'b0, 5);
      check("glitch_busy_rise", 32'(rx_busy), 32'd1);
      drive(1'b1, BP);
      check_idle_outputs("glitch_after", 8'hFF);

      send_frame(8'h3C, 1'b1, 3);
      drive(1'b1, 4);
      check_idle_outputs("ferr_after", 8'hFF);

      // Abort 8'h81 partway through its fourth data bit
      drive(1'b0, BP);
      for (int i = 0; i < 3; i++) drive(1'(8'h81 >> i), BP);
      drive(1'b0, BP / 2);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_reset", 8'h00);
      last_good = 8'h00;
      exp_q.delete();
      rst = 1'b0;
      drive(1'b1, 4);
      send_frame(8'h81, 1'b1, 0);
      drive(1'b1, 4);
      check_idle_outputs("after_reset", 8'h81);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 0);
      drive(1'b1, 4);
      check_idle_outputs("par_bad", 8'h81);
      send_frame(8'h07, 1'b1, 0);
      drive(1'b1, 4);
      check_idle_outputs("par_good", 8'h07);
`endif

      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         int         sl;
         bit         pg;
         d  = 8'($urandom_range(0, 255));
         sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
         pg = ($urandom_range(0, 3) != 0);
         send_frame(d, pg, sl);
         drive(1'b1, int'($urandom_range(0, 10)));
      end

      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      drive(1'b1, 4);
      check("final_busy", 32'(rx_busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive end of the 8N1 link driven by the team's UART transmitter. Synchronises the asynchronous `rx` line, detects and validates the start bit, samples each data bit at mid-period, checks the stop bit, and presents one received byte per frame with a single-cycle valid strobe. Sits between the board's RX pin and the command or byte-consumer logic on the Basys 3 design.

## Interface
- `CLOCK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `rx`  in  1  asynchronous UART line; idles high.
- `data_out`  out  8  last correctly framed byte, LSB received first.
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.
- `rx_busy`  out  1  high from start-bit detection until the return to IDLE.

## Operation
- `BIT_PERIOD = CLOCK_FREQ / BAUD_RATE` (integer division; 10416 by default). `HALF_PERIOD = BIT_PERIOD / 2`.
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions below use the synchronised signal `rx_s`.
- State machine:
  - IDLE: `rx_s`==0 → clear tick counter, set `rx_busy`, go to START_BIT.
  - START_BIT: count to `HALF_PERIOD`-1, then sample. If `rx_s`==1 the start was a glitch: clear `rx_busy` and go to IDLE with no pulse. Otherwise clear the counters and go to DATA_BITS.
  - DATA_BITS: count to `BIT_PERIOD`-1, then sample `rx_s` into `shift_reg[7]`, shifting right so the first bit ends in bit 0. After the 8th sample go to STOP_BIT, or to PARITY_BIT when parity is enabled.
  - PARITY_BIT (macro only): count to `BIT_PERIOD`-1, then sample and compare with even parity of the 8 data bits. Store the mismatch flag and go to STOP_BIT.
  - STOP_BIT: count to `BIT_PERIOD`-1, then sample.
    - `rx_s`==1 and no parity mismatch → load `data_out` from `shift_reg` and pulse `data_valid`.
    - `rx_s`==1 with a parity mismatch → pulse `parity_err`; `data_out` is unchanged.
    - `rx_s`==0 → pulse `frame_err`; `data_out` is unchanged, and the parity check is not reported for that frame.
    - Then go to CLEANUP.
  - CLEANUP: stay until `rx_s`==1 (break or held-low line), then clear `rx_busy` and go to IDLE. A correctly framed byte leaves after 1 cycle.
- Counters: tick counter is wide enough for `BIT_PERIOD`-1; bit counter is 3 bits, and wrap from 7 ends the data phase.
- `data_valid`, `frame_err` and `parity_err` are mutually exclusive and never assert for more than one cycle.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0, state=IDLE, synchroniser=1.
- Reset mid-frame aborts the frame immediately with no pulse.
- Synchroniser latency is 2 cycles. `rx_busy` rises 3 cycles after the falling edge on `rx` (2 sync + 1 registered).
- Start-bit sample falls `HALF_PERIOD` cycles after entry to START_BIT. Each data sample follows the previous one by exactly `BIT_PERIOD` cycles.
- `data_valid` asserts on the cycle after the stop-bit sample, about 9.5 bit periods plus 3 cycles after the start edge (10.5 periods with parity).
- A new start edge is accepted on the first IDLE cycle after CLEANUP. Back-to-back frames with a 1-bit stop need no extra idle time.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1, PARITY_BIT is compiled in, and `parity_err` is live.
- Not defined: the frame is 8N1, the PARITY_BIT state and its logic are absent, and `parity_err` is constant 0.
- The port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, CLEANUP);
  - function computing the bit period from frequency and baud rate;
  - constant `UART_DATA_BITS`=8.
- One sub-module: `sync_2ff`, a parameter-free 2-flop synchroniser with asynchronous set to 1. It is reusable for other pins.

## Test plan
Benches use `CLOCK_FREQ`=160, `BAUD_RATE`=10, giving `BIT_PERIOD`=16.
- Send 8'hA5 in 8N1 → `data_out`=8'hA5, one `data_valid` pulse, no error pulses, `rx_busy` low afterwards.
- Send 8'h00, then 8'hFF back-to-back with 1 stop bit → two `data_valid` pulses with data 00 then FF.
- Drive `rx` low for 5 cycles, then high → no pulses; `rx_busy` returns to 0 after the half-period check.
- Send 8'h3C with the stop bit held low for 3 bit periods → `frame_err` pulses once, `data_out` is unchanged, and `rx_busy` stays high until the line goes high.
- Assert `rst` during the 4th data bit of 8'h81 → all outputs return to reset values; the next frame 8'h81 is received correctly.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 0 → `parity_err` pulses; with parity bit 1 → `data_valid` pulses and `data_out`=8'h07.
